// File: rtl/ks_mp_add_seq.sv
// ks_mp_add_seq
// -----------------------------------------------------------------------------
// Sequencer that runs multi-precision additions over an external bw-bit adder,
// one word per beat, least-significant word first. It drives the adder
// operands, chains the adder carry-out back into carry-in between the words of
// one operation, and captures each word result in a registered output stage.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     operand stream handshake
//   in_a, in_b            operand words
//   in_first, in_last     LSW / MSW markers of an operation
//   in_cin                initial carry (only used on the first word)
//   add_a, add_b, add_cin to the adder (combinational)
//   add_sum, add_cout     from the adder
//   out_valid/out_ready   result stream handshake
//   out_sum, out_last     registered result word and its MSW marker
//   out_cout, out_ovf     final carry / signed overflow (MSW only, else 0)
//   out_idx               word index of out_sum inside its operation
//   err_len               sticky: an operation ran past MAX_WORDS words
//   dbg_state             current FSM state (0 = idle, 1 = chaining)
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1.
// valid never depends on ready; in_ready = !out_valid || out_ready, so the
// output register either is empty or is being drained in the same cycle it is
// reloaded, giving one word per cycle throughput. in_ready is 0 during reset.
// -----------------------------------------------------------------------------
module ks_mp_add_seq #(
  parameter int bw        = 16,
  parameter int MAX_WORDS = 8,
  localparam int IW       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bw-1:0] in_a,
  input  logic [bw-1:0] in_b,
  input  logic          in_first,
  input  logic          in_last,
  input  logic          in_cin,
  output logic [bw-1:0] add_a,
  output logic [bw-1:0] add_b,
  output logic          add_cin,
  input  logic [bw-1:0] add_sum,
  input  logic          add_cout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bw-1:0] out_sum,
  output logic          out_last,
  output logic          out_cout,
  output logic          out_ovf,
  output logic [IW-1:0] out_idx,
  output logic          err_len,
  output logic          dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHAIN = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_WORDS - 1);

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            out_valid_q, out_valid_d;
  logic [bw-1:0]   out_sum_q, out_sum_d;
  logic            out_last_q, out_last_d;
  logic            out_cout_q, out_cout_d;
  logic            out_ovf_q, out_ovf_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;

  logic            in_fire;
  logic            out_fire;
  logic            start_word;
  logic [IW-1:0]   cur_idx;

  // A word starts a new operation when flagged first, or when nothing is in
  // flight (a non-first word arriving while idle is treated as a first word).
  assign start_word = (state_q == ST_IDLE) || in_first;
  assign cur_idx    = start_word ? '0 : cnt_q;

  assign in_ready = rst_n && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign add_a   = in_a;
  assign add_b   = in_b;
  assign add_cin = start_word ? in_cin : carry_q;

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    out_idx_d   = out_idx_q;

    if (in_fire) begin
      carry_d     = add_cout;
      out_valid_d = 1'b1;
      out_sum_d   = add_sum;
      out_last_d  = in_last;
      out_idx_d   = cur_idx;
      out_cout_d  = add_cout & in_last;
      out_ovf_d   = in_last & (in_a[bw-1] == in_b[bw-1]) & (add_sum[bw-1] != in_a[bw-1]);

      if (in_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else if (start_word) begin
        state_d = ST_CHAIN;
        cnt_d   = IW'(1);
      end else if (cnt_q == LAST_IDX) begin
        // Overlong operation: flag it, hold the index, keep chaining the carry.
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IW'(1);
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_idx   = out_idx_q;
  assign err_len   = err_q;
  assign dbg_state = state_q;

endmodule
